serial_decrypt_receiver: RTL and testbench
==========================================

Name: serial_decrypt_receiver

Overview:
- Receive-side peer of the cipher's framed serial output (data bit + start/end strobes).
- Deserializes one ciphertext frame and XOR-decrypts it on the fly with a repeating key.
- Presents the recovered plaintext in parallel.
- Used on the loopback/verification path and in the host-side decrypt core.

Parameters:
KEY_SIZE, 32, key width in bits; key repeats every KEY_SIZE message bits
MSG_SIZE, 512, plaintext buffer depth in bits

Ports:
iClk  input  1  clock; all logic on rising edge
iRst  input  1  synchronous, active-high reset
iEn  input  1  sample enable; low = all state frozen, no bit consumed
iKey  input  KEY_SIZE  decryption key, sampled only on frame start
iKey_valid  input  1  key usable; a start with this low is rejected
iSerial_in  input  1  serial ciphertext bit, LSB (message bit 0) first
iSerial_start  input  1  high on cycle carrying bit 0 of a frame
iSerial_end  input  1  high on cycle carrying last bit of a frame
oPlaintext  output  MSG_SIZE  decrypted message; bit i = cipher bit i XOR key[i mod KEY_SIZE]
oBit_counter  output  $clog2(MSG_SIZE)+1  bits stored in current/last frame
oBusy  output  1  frame in progress
oDone  output  1  level; plaintext valid, held until next accepted start or reset
oOverflow  output  1  sticky per frame; frame exceeded MSG_SIZE bits
oFrame_error  output  1  sticky per frame; protocol violation
oCipher_parity  output  1  XOR of all stored cipher bits (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, key shadow 0, key index 0.
- Bits are sampled only on cycles with iEn=1. Strobes are also ignored when iEn=0.
- States:
  - IDLE
    - start & iKey_valid: latch iKey into shadow; clear plaintext, counter, flags; store bit 0 → RECV.
    - If end is also high in the same cycle → DONE (1-bit frame).
    - start & !iKey_valid: set oFrame_error, stay IDLE.
    - end without start: ignored.
  - RECV
    - Each enabled cycle stores one bit at position oBit_counter, then increments the counter.
    - end on a bit → that bit is stored → DONE.
    - start while in RECV: set oFrame_error, discard partial frame, restart as a new frame from this bit. oFrame_error stays set for the new frame.
  - DONE
    - oDone=1. Outputs hold.
    - start (with valid key) → behaves as the IDLE start: clears oDone and flags.
- Latency: oDone and the final oPlaintext/oBit_counter are visible the cycle after the end bit is sampled.
- Key index: increments per stored bit and wraps KEY_SIZE-1→0. It resets to 0 at every frame start.
- Changes on iKey mid-frame have no effect; only the shadow copy is used.
- Overflow:
  - Once oBit_counter==MSG_SIZE, further bits are dropped and oOverflow is set.
  - The counter saturates at MSG_SIZE.
  - The frame still terminates on end.
- oBusy=1 in RECV only.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro RX_CIPHER_PARITY_EN.
- Defined: oCipher_parity is a running XOR of every stored (non-overflow) ciphertext bit. It clears at frame start and is held in DONE.
- Undefined: oCipher_parity tied 0; no parity flop.

Decomposition:
- Package xor_cipher_pkg:
  - rx_state_t enum {IDLE, RECV, DONE}
  - DEFAULT_KEY_SIZE=32, DEFAULT_MSG_SIZE=512
  - counter-width function clog2(MSG_SIZE)+1
- Sub-module key_rotator:
  - Holds the key shadow and wrapping index.
  - Outputs the current key bit.
  - Inputs: load, advance.

Test Plan:
1. Key 0xA5A5A5A5; 32-bit frame carrying 0xDEADBEEF LSB-first, start on bit 0, end on bit 31 → next cycle oDone=1, oPlaintext[31:0]=0x7B081B4A, oBit_counter=32, flags 0.
2. Key 0x00000001; 40 zero bits → oPlaintext[39:0]=0x0100000001 (key wraps at bit 32), counter=40.
3. 520-bit frame, MSG_SIZE=512 → oOverflow=1, counter=512, bits 512..519 absent, oDone=1 after end.
4. Start, 10 bits, second start, then 8 bits ending with end → oFrame_error=1, counter=8, plaintext reflects only the second frame.
5. 16-bit frame with iEn low every other cycle (strobes/data held during gaps) → identical result to the gap-free frame. Then iRst=1 mid-way through a second frame → all outputs 0 the next cycle.
6. RX_CIPHER_PARITY_EN defined, frame 0xDEADBEEF → oCipher_parity=0 (24 ones). Macro undefined → oCipher_parity=0 always. Frame 0x00000001 with the macro defined → oCipher_parity=1.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// Shared types and sizing helpers for the XOR-cipher serial receive path.
package xor_cipher_pkg;

   typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;

   localparam int unsigned DEFAULT_KEY_SIZE = 32;
   localparam int unsigned DEFAULT_MSG_SIZE = 512;

   // Counter must hold MSG_SIZE itself, hence one bit beyond the index width.
   function automatic int unsigned cnt_width(input int unsigned msg_size);
      return $clog2(msg_size) + 1;
   endfunction

endpackage

// File: rtl/key_rotator.sv
// Key shadow register with a wrapping bit index; supplies the key bit for the current message bit.
module key_rotator #(
   parameter int unsigned KEY_SIZE = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic                advance_i,
   input  logic [KEY_SIZE-1:0] key_i,
   output logic                key_bit_o
);

   localparam int unsigned IdxW = (KEY_SIZE > 1) ? $clog2(KEY_SIZE) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(KEY_SIZE - 1);

   logic [KEY_SIZE-1:0] shadow_q, shadow_d;
   logic [IdxW-1:0]     idx_q, idx_d;

   always_comb begin
      shadow_d = shadow_q;
      idx_d    = idx_q;
      if (load_i) begin
         // The load cycle consumes key bit 0, so the next bit uses index 1.
         shadow_d = key_i;
         idx_d    = (KEY_SIZE > 1) ? IdxW'(1) : '0;
      end else if (advance_i) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         idx_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
      end
   end

   assign key_bit_o = load_i ? key_i[0] : shadow_q[idx_q];

endmodule

// File: rtl/serial_decrypt_receiver.sv
// Deserializes a framed ciphertext stream and XOR-decrypts it with a repeating key.
// Optional running ciphertext parity enabled by defining RX_CIPHER_PARITY_EN.
module serial_decrypt_receiver
   import xor_cipher_pkg::*;
#(
   parameter int unsigned KEY_SIZE = DEFAULT_KEY_SIZE,
   parameter int unsigned MSG_SIZE = DEFAULT_MSG_SIZE
) (
   input  logic                             iClk,
   input  logic                             iRst,
   input  logic                             iEn,
   input  logic [KEY_SIZE-1:0]              iKey,
   input  logic                             iKey_valid,
   input  logic                             iSerial_in,
   input  logic                             iSerial_start,
   input  logic                             iSerial_end,
   output logic [MSG_SIZE-1:0]              oPlaintext,
   output logic [cnt_width(MSG_SIZE)-1:0]   oBit_counter,
   output logic                             oBusy,
   output logic                             oDone,
   output logic                             oOverflow,
   output logic                             oFrame_error,
   output logic                             oCipher_parity
);

   localparam int unsigned CW = cnt_width(MSG_SIZE);
   localparam int unsigned IW = (MSG_SIZE > 1) ? $clog2(MSG_SIZE) : 1;
   localparam logic [CW-1:0] CntMax = CW'(MSG_SIZE);

   rx_state_t           state_q, state_d;
   logic [MSG_SIZE-1:0] pt_q, pt_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                ferr_q, ferr_d;
   logic                load, adv, key_bit;

   key_rotator #(
      .KEY_SIZE(KEY_SIZE)
   ) u_key_rotator (
      .clk_i    (iClk),
      .rst_i    (iRst),
      .load_i   (load),
      .advance_i(adv),
      .key_i    (iKey),
      .key_bit_o(key_bit)
   );

   always_comb begin
      state_d = state_q;
      pt_d    = pt_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      ferr_d  = ferr_q;
      load    = 1'b0;
      adv     = 1'b0;
      if (iEn) begin
         if (iSerial_start) begin
            if (iKey_valid) begin
               load    = 1'b1;
               pt_d    = '0;
               pt_d[0] = iSerial_in ^ key_bit;
               cnt_d   = CW'(1);
               ovf_d   = 1'b0;
               // A start landing mid-frame is a protocol error that sticks to the new frame.
               ferr_d  = (state_q == RECV);
               state_d = iSerial_end ? DONE : RECV;
            end else begin
               ferr_d = 1'b1;
               if (state_q == RECV) state_d = IDLE;
            end
         end else if (state_q == RECV) begin
            if (cnt_q < CntMax) begin
               pt_d[cnt_q[IW-1:0]] = iSerial_in ^ key_bit;
               cnt_d               = cnt_q + CW'(1);
               adv                 = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
            if (iSerial_end) state_d = DONE;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         pt_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pt_q    <= pt_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
      end
   end

`ifdef RX_CIPHER_PARITY_EN
   logic par_q;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         par_q <= 1'b0;
      end else if (load) begin
         par_q <= iSerial_in;
      end else if (adv) begin
         par_q <= par_q ^ iSerial_in;
      end
   end

   assign oCipher_parity = par_q;
`else
   assign oCipher_parity = 1'b0;
`endif

   assign oPlaintext   = pt_q;
   assign oBit_counter = cnt_q;
   assign oBusy        = (state_q == RECV);
   assign oDone        = (state_q == DONE);
   assign oOverflow    = ovf_q;
   assign oFrame_error = ferr_q;

endmodule

// File: tb/tb_serial_decrypt_receiver.sv
// Scoreboard bench for serial_decrypt_receiver: frames are modelled when driven, checked on oDone.
module tb_serial_decrypt_receiver;

   localparam int unsigned KS = 32;
   localparam int unsigned MS = 512;
   localparam int unsigned CW = $clog2(MS) + 1;

   typedef struct {
      logic [MS-1:0] pt;
      int            cnt;
      bit            ovf;
      bit            ferr;
      bit            par;
   } exp_t;

   logic              iClk = 1'b0;
   logic              iRst, iEn, iKey_valid, iSerial_in, iSerial_start, iSerial_end;
   logic [KS-1:0]     iKey;
   logic [MS-1:0]     oPlaintext;
   logic [CW-1:0]     oBit_counter;
   logic              oBusy, oDone, oOverflow, oFrame_error, oCipher_parity;

   exp_t              sb[$];
   int                n_vec = 0;
   int                n_err = 0;
   logic              done_prev = 1'b0;
   logic [1023:0]     cbuf;

   serial_decrypt_receiver #(
      .KEY_SIZE(KS),
      .MSG_SIZE(MS)
   ) dut (
      .iClk          (iClk),
      .iRst          (iRst),
      .iEn           (iEn),
      .iKey          (iKey),
      .iKey_valid    (iKey_valid),
      .iSerial_in    (iSerial_in),
      .iSerial_start (iSerial_start),
      .iSerial_end   (iSerial_end),
      .oPlaintext    (oPlaintext),
      .oBit_counter  (oBit_counter),
      .oBusy         (oBusy),
      .oDone         (oDone),
      .oOverflow     (oOverflow),
      .oFrame_error  (oFrame_error),
      .oCipher_parity(oCipher_parity)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [MS-1:0] got, input logic [MS-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare each completed frame against the oldest queued expectation.
   always @(negedge iClk) begin
      if (oDone && !done_prev) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            check("plaintext", oPlaintext, sb[0].pt);
            check("bit_counter", MS'(oBit_counter), MS'(sb[0].cnt));
            check("overflow", MS'(oOverflow), MS'(sb[0].ovf));
            check("frame_error", MS'(oFrame_error), MS'(sb[0].ferr));
            check("parity", MS'(oCipher_parity), MS'(sb[0].par));
            check("busy_at_done", MS'(oBusy), 0);
            void'(sb.pop_front());
         end
      end
      done_prev <= oDone;
   end

   function automatic exp_t model(input logic [1023:0] c, input int n, input logic [KS-1:0] key,
                                  input bit ferr);
      exp_t e;
      e.pt   = '0;
      e.par  = 1'b0;
      e.ferr = ferr;
      for (int i = 0; i < n && i < int'(MS); i++) begin
         e.pt[i] = c[i] ^ key[i % KS];
         e.par   = e.par ^ c[i];
      end
      e.cnt = (n > int'(MS)) ? int'(MS) : n;
      e.ovf = (n > int'(MS));
`ifndef RX_CIPHER_PARITY_EN
      e.par = 1'b0;
`endif
      return e;
   endfunction

   task automatic idle_inputs();
      iEn           = 1'b0;
      iSerial_in    = 1'b0;
      iSerial_start = 1'b0;
      iSerial_end   = 1'b0;
   endtask

   // Key is presented only with bit 0; later cycles scramble iKey to prove the shadow is used.
   task automatic drive(input logic [1023:0] c, input int n, input logic [KS-1:0] key,
                        input bit gaps, input bit with_end);
      for (int i = 0; i < n; i++) begin
         @(negedge iClk);
         iEn           = 1'b1;
         iKey_valid    = 1'b1;
         iKey          = (i == 0) ? key : KS'($urandom);
         iSerial_in    = c[i];
         iSerial_start = (i == 0);
         iSerial_end   = with_end && (i == n - 1);
         if (gaps && i != n - 1) begin
            @(negedge iClk);
            iEn = 1'b0;
         end
      end
      @(negedge iClk);
      idle_inputs();
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge iClk);
      check("sb_drain", MS'(sb.size()), 0);
   endtask

   task automatic send_frame(input logic [1023:0] c, input int n, input logic [KS-1:0] key,
                             input bit gaps);
      sb.push_back(model(c, n, key, 1'b0));
      drive(c, n, key, gaps, 1'b1);
      wait_drain();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pt"}, oPlaintext, '0);
      check({tag, "_cnt"}, MS'(oBit_counter), 0);
      check({tag, "_flags"}, MS'({oBusy, oDone, oOverflow, oFrame_error, oCipher_parity}), 0);
   endtask

   task automatic rand_bits();
      for (int i = 0; i < 1024; i++) cbuf[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      exp_t e;
      iKey       = '0;
      iKey_valid = 1'b0;
      idle_inputs();
      iRst = 1'b1;
      repeat (2) @(negedge iClk);
      iRst = 1'b0;
      check_all_zero("reset");

      // Invalid-key start is rejected; a stray end in IDLE is ignored.
      @(negedge iClk);
      iEn = 1'b1; iSerial_start = 1'b1; iKey_valid = 1'b0; iSerial_in = 1'b1;
      @(negedge iClk);
      iSerial_start = 1'b0; iSerial_end = 1'b1;
      check("badkey_ferr", MS'(oFrame_error), 1);
      check("badkey_busy", MS'(oBusy), 0);
      @(negedge iClk);
      idle_inputs();
      check("stray_end", MS'({oBusy, oDone}), 0);

      // 1: known vector.
      cbuf = '0; cbuf[31:0] = 32'hDEADBEEF;
      send_frame(cbuf, 32, 32'hA5A5A5A5, 1'b0);
      check("t1_pt_const", oPlaintext[31:0], 32'h7B081B4A);
      check("t1_done_held", MS'(oDone), 1);

      // 2: key wraps at bit 32.
      cbuf = '0;
      send_frame(cbuf, 40, 32'h00000001, 1'b0);
      check("t2_pt_const", oPlaintext[39:0], 40'h0100000001);

      // 3: overflow.
      rand_bits();
      send_frame(cbuf, 520, 32'h3C5A96F0, 1'b0);

      // 4: restart mid-frame.
      rand_bits();
      drive(cbuf, 10, 32'h11111111, 1'b0, 1'b0);
      rand_bits();
      e = model(cbuf, 8, 32'h87654321, 1'b1);
      sb.push_back(e);
      drive(cbuf, 8, 32'h87654321, 1'b0, 1'b1);
      wait_drain();

      // 5: enable gaps give the same result, then reset mid-frame.
      cbuf = '0; cbuf[15:0] = 16'hC3A7;
      send_frame(cbuf, 16, 32'h0F0F1234, 1'b0);
      send_frame(cbuf, 16, 32'h0F0F1234, 1'b1);
      rand_bits();
      drive(cbuf, 6, 32'hFFFF0000, 1'b0, 1'b0);
      check("t5_busy", MS'(oBusy), 1);
      check("t5_cnt_mid", MS'(oBit_counter), 6);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      check_all_zero("t5_rst");

      // 1-bit frame: start and end together.
      cbuf = '0; cbuf[0] = 1'b1;
      send_frame(cbuf, 1, 32'h00000001, 1'b0);

      // 6: parity of a single-one frame.
      cbuf = '0; cbuf[31:0] = 32'h00000001;
      send_frame(cbuf, 32, 32'h12345678, 1'b0);

      check("sb_final", MS'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
